register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers (>=2, power of two not required).
- AW, $clog2(NREGS), register address width.
- NRD, 2, number of independent read ports (>=1).

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous active-low reset; 0 = reset asserted.
- wr_en, in, 1, write-back strobe.
- wr_addr, in, AW, write-back register index.
- wr_data, in, XLEN, write-back data.
- rd_en, in, NRD, per-port read request.
- rd_addr, in, NRD*AW, per-port read index; port i at bits [i*AW +: AW].
- rd_data, out, NRD*XLEN, registered read data; port i at bits [i*XLEN +: XLEN].
- rd_valid, out, NRD, per-port flag: rd_data[i] updated by a read at the previous edge.
- rsv_en, in, 1, reserve a destination register (instruction issue).
- rsv_addr, in, AW, register index to reserve.
- flush, in, 1, clear all reservations (pipeline flush).
- busy, out, NRD, combinational: the register addressed by read port i has a pending write.
- busy_vec, out, NREGS, current pending-bit vector, bit n = register n.

Function
REQ-003 Storage SHALL be NREGS entries of XLEN bits. Register 0 SHALL always read as zero and SHALL never become pending.
REQ-004 At a rising edge with wr_en=1 and 0<wr_addr<NREGS, entry wr_addr SHALL take wr_data. Writes to 0 or to an index >=NREGS SHALL be ignored.
REQ-005 Reads SHALL have 1-cycle latency. At an edge with rd_en[i]=1, rd_data[i] SHALL load the entry at rd_addr[i], with these overrides:
- address 0 or >=NREGS: load 0.
- same-edge write with wr_en=1 and wr_addr==rd_addr[i]!=0: load wr_data (write-through bypass).
REQ-006 With rd_en[i]=0, rd_data[i] SHALL hold its value, and rd_valid[i] SHALL be 0 after that edge. rd_valid[i] SHALL equal rd_en[i] sampled at the previous edge.
REQ-007 All NRD ports SHALL operate independently and concurrently. Ports may address the same register in the same cycle.
REQ-008 A pending bit per register SHALL be updated at each rising edge, in priority order:
- (1) flush=1: all bits cleared; rsv_en and the pending-bit effect of wr_en are ignored; the data write still occurs.
- (2) rsv_en=1 with rsv_addr!=0: pending[rsv_addr] is set.
- (3) wr_en=1: pending[wr_addr] is cleared.
- rsv_addr==wr_addr on the same edge: set wins (new WAW reservation).
REQ-009 busy[i] SHALL equal pending[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]), so a same-cycle write-back resolves the hazard through the bypass. busy[i] SHALL be 0 for address 0 or >=NREGS.
REQ-010 A write to a non-pending register SHALL be legal and SHALL leave its pending bit at 0. Reserving an already pending register SHALL keep it pending.
REQ-011 busy_vec SHALL reflect the pending bits directly, with bit 0 constant 0.

Reset
REQ-012 While reset=0, asynchronously:
- all register entries, rd_data and rd_valid SHALL be 0.
- all pending bits SHALL be 0, so busy and busy_vec are 0.
REQ-013 Reset asserted during operation SHALL discard in-flight reads and reservations. The first edge after reset=1 SHALL behave as a normal cycle.

Verification
REQ-014 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Write x1=0xBEEFDEAD, then write x0=0xDEADBEEF; read both on ports 0 and 1 -> next cycle rd_data0=0xBEEFDEAD (x1), rd_data1=0, rd_valid=2'b11.
- Same edge: wr x5=0x12345678 and rd_en[0] with addr 5 -> rd_data0=0x12345678 one cycle later.
- rsv x7 -> busy_vec[7]=1, busy0=1 for rd_addr0=7. Next cycle wr_en x7 -> busy0=0 combinationally; pending[7]=0 after the edge.
- Same edge: rsv x9 and wr x9 -> pending[9]=1 after the edge, entry x9 updated.
- Reserve x3, x4, x6; assert flush together with rsv x8 -> busy_vec all 0 after the edge, register data unchanged.
- Mid-stream reset=0 with pending bits and nonzero data -> immediately all outputs 0. After release, read x1 -> 0.

Source files
------------

// File: rtl/register_file_sb.sv
// Integer register file with registered read ports, write-through bypass and a
// per-register pending (scoreboard) bit for issue-time hazard detection.

module rf_read_port #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [AW-1:0]               addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            pending,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN-1:0]             wr_data,
    output logic [XLEN-1:0]             data,
    output logic                        valid,
    output logic                        busy
);
    logic addr_ok;
    logic hit;

    assign addr_ok = (addr != '0) && ({1'b0, addr} < (AW+1)'(NREGS));
    assign hit     = wr_en && (wr_addr == addr);
    // A same-cycle write-back resolves the hazard because the bypass supplies it.
    assign busy    = addr_ok && pending[addr] && !hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                if (!addr_ok)
                    data <= '0;
                else if (hit)
                    data <= wr_data;
                else
                    data <= regs[addr];
            end
        end
    end
endmodule

module register_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_valid,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic [NRD-1:0]       busy,
    output logic [NREGS-1:0]     busy_vec
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           pending;
    logic [NREGS-1:0]           pend_nxt;
    logic                       wr_ok;
    logic                       rsv_ok;

    assign wr_ok  = (wr_addr  != '0) && ({1'b0, wr_addr}  < (AW+1)'(NREGS));
    assign rsv_ok = (rsv_addr != '0) && ({1'b0, rsv_addr} < (AW+1)'(NREGS));

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            regs <= '0;
        else if (wr_en && wr_ok)
            regs[wr_addr] <= wr_data;
    end

    // Reservation is applied after the clear so a same-index WAW stays pending.
    always_comb begin
        pend_nxt = pending;
        if (wr_en && wr_ok)
            pend_nxt[wr_addr] = 1'b0;
        if (rsv_en && rsv_ok)
            pend_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else if (flush)
            pending <= '0;
        else
            pending <= pend_nxt;
    end

    assign busy_vec = pending;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rf_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .clk     (clk),
            .reset   (reset),
            .en      (rd_en[i]),
            .addr    (rd_addr[i*AW +: AW]),
            .regs    (regs),
            .pending (pending),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[i*XLEN +: XLEN]),
            .valid   (rd_valid[i]),
            .busy    (busy[i])
        );
    end
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed hazard/bypass/reset scenarios followed by
// randomized traffic, all compared every cycle against an array-based model.

module tb_register_file_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                 clk;
    logic                 reset;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_valid;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;
    logic                 flush;
    logic [NRD-1:0]       busy;
    logic [NREGS-1:0]     busy_vec;

    int checks = 0;
    int errors = 0;

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain arrays updated by the architectural rules.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    logic [XLEN-1:0] m_rd   [NRD];
    logic [NRD-1:0]  m_vld;
    int              ma;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NREGS; n++) begin
                m_regs[n] = '0;
                m_pend[n] = 1'b0;
            end
            for (int i = 0; i < NRD; i++) m_rd[i] = '0;
            m_vld = '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    ma = int'(rd_addr[i*AW +: AW]);
                    if (ma == 0 || ma >= NREGS)             m_rd[i] = '0;
                    else if (wr_en && int'(wr_addr) == ma)  m_rd[i] = wr_data;
                    else                                    m_rd[i] = m_regs[ma];
                end
            end
            m_vld = rd_en;
            if (wr_en && wr_addr != 0 && int'(wr_addr) < NREGS)
                m_regs[wr_addr] = wr_data;
            if (flush) begin
                for (int n = 0; n < NREGS; n++) m_pend[n] = 1'b0;
            end else begin
                if (wr_en && wr_addr != 0 && int'(wr_addr) < NREGS)
                    m_pend[wr_addr] = 1'b0;
                if (rsv_en && rsv_addr != 0 && int'(rsv_addr) < NREGS)
                    m_pend[rsv_addr] = 1'b1;
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        logic [NREGS-1:0] ev;
        int a;
        logic eb;
        for (int n = 0; n < NREGS; n++) ev[n] = m_pend[n];
        chk("busy_vec", 64'(busy_vec), 64'(ev));
        chk("rd_valid", 64'(rd_valid), 64'(m_vld));
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(m_rd[i]));
            a  = int'(rd_addr[i*AW +: AW]);
            eb = (a != 0) && (a < NREGS) && m_pend[a] && !(wr_en && int'(wr_addr) == a);
            chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(eb));
        end
    end

    task automatic idle();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        reset = 0;
        idle();
        tick(); tick();
        chk("reset_rd_data", 64'(rd_data), 64'h0);
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        reset = 1;

        // x1 written, x0 write ignored, both read back
        idle(); wr_en = 1; wr_addr = 5'd1; wr_data = 32'hBEEFDEAD; tick();
        idle(); wr_en = 1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; tick();
        idle(); set_rd(0, 5'd1); set_rd(1, 5'd0); tick();
        chk("dir_x1", 64'(rd_data[31:0]), 64'hBEEFDEAD);
        chk("dir_x0", 64'(rd_data[63:32]), 64'h0);
        chk("dir_valid", 64'(rd_valid), 64'h3);

        // write-through bypass
        idle(); wr_en = 1; wr_addr = 5'd5; wr_data = 32'h12345678; set_rd(0, 5'd5); tick();
        chk("dir_bypass", 64'(rd_data[31:0]), 64'h12345678);

        // reserve then resolve
        idle(); rsv_en = 1; rsv_addr = 5'd7; tick();
        idle(); rd_addr[AW-1:0] = 5'd7; #1;
        chk("dir_busy7", 64'(busy[0]), 64'h1);
        chk("dir_vec7", 64'(busy_vec[7]), 64'h1);
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'h77; #1;
        chk("dir_busy7_wb", 64'(busy[0]), 64'h0);
        tick();
        idle(); #1;
        chk("dir_vec7_clr", 64'(busy_vec[7]), 64'h0);

        // WAW: reserve and write same register on same edge
        idle(); rsv_en = 1; rsv_addr = 5'd9; wr_en = 1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009; tick();
        idle(); #1;
        chk("dir_vec9", 64'(busy_vec[9]), 64'h1);
        set_rd(0, 5'd9); tick();
        chk("dir_x9", 64'(rd_data[31:0]), 64'hA5A5_0009);

        // flush beats a simultaneous reservation
        idle(); rsv_en = 1; rsv_addr = 5'd3; tick();
        idle(); rsv_en = 1; rsv_addr = 5'd4; tick();
        idle(); rsv_en = 1; rsv_addr = 5'd6; tick();
        chk("dir_vec346", 64'(busy_vec), 64'h0000_0258);
        idle(); flush = 1; rsv_en = 1; rsv_addr = 5'd8; tick();
        idle(); #1;
        chk("dir_flush", 64'(busy_vec), 64'h0);
        set_rd(0, 5'd1); set_rd(1, 5'd5); tick();
        chk("dir_keep_x1", 64'(rd_data[31:0]), 64'hBEEFDEAD);
        chk("dir_keep_x5", 64'(rd_data[63:32]), 64'h12345678);

        // asynchronous reset mid-stream
        idle(); rsv_en = 1; rsv_addr = 5'd10; set_rd(0, 5'd1); tick();
        idle(); reset = 0; #1;
        chk("dir_arst_data", 64'(rd_data), 64'h0);
        chk("dir_arst_valid", 64'(rd_valid), 64'h0);
        chk("dir_arst_vec", 64'(busy_vec), 64'h0);
        tick();
        reset = 1; set_rd(0, 5'd1); tick();
        chk("dir_post_x1", 64'(rd_data[31:0]), 64'h0);
        chk("dir_post_valid", 64'(rd_valid), 64'h1);

        // randomized traffic, small address range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset    = ($urandom_range(0, 299) != 0);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wr_data  = $urandom;
            rd_en    = 2'($urandom);
            for (int p = 0; p < NRD; p++)
                rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle(); reset = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
